// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue stage.
// Defines ALU opcodes, RV32 major opcodes, buffer states and the issue bundle.
package alu_pkg;

   localparam logic [3:0] ALU_OP_ADD     = 4'b0000;
   localparam logic [3:0] ALU_OP_SLL     = 4'b0001;
   localparam logic [3:0] ALU_OP_SLT     = 4'b0010;
   localparam logic [3:0] ALU_OP_SLTU    = 4'b0011;
   localparam logic [3:0] ALU_OP_XOR     = 4'b0100;
   localparam logic [3:0] ALU_OP_SRL     = 4'b0101;
   localparam logic [3:0] ALU_OP_OR      = 4'b0110;
   localparam logic [3:0] ALU_OP_AND     = 4'b0111;
   localparam logic [3:0] ALU_OP_SUB     = 4'b1000;
   localparam logic [3:0] ALU_OP_SRA     = 4'b1101;
   localparam logic [3:0] ALU_OP_ILLEGAL = 4'b1111;

   localparam logic [6:0] RV_OP     = 7'b0110011;
   localparam logic [6:0] RV_OP_IMM = 7'b0010011;
   localparam logic [6:0] RV_LUI    = 7'b0110111;
   localparam logic [6:0] RV_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_FULL  = 2'd2
   } buf_state_e;

   typedef struct packed {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [3:0]  opcode;
      logic [4:0]  rd;
      logic        illegal;
   } issue_t;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == ALU_OP_SLL) || (op == ALU_OP_SRL) ||
             (op == ALU_OP_SRA);
   endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I OP/OP-IMM/LUI/AUIPC decoder producing an issue_t.
// Ports: instr_in, rs1_data_in, rs2_data_in, pc_in -> dec_out.
// Macro ALU_ISSUE_ILLEGAL_CHK_EN: flag unsupported encodings as illegal.
module alu_issue_decode
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] instr_in,
   input  logic [XLEN-1:0] rs1_data_in,
   input  logic [XLEN-1:0] rs2_data_in,
   input  logic [XLEN-1:0] pc_in,
   output issue_t          dec_out
);

   logic [6:0]  maj;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i;
   logic [31:0] imm_u;
   logic        is_op;
   logic        is_imm;
   logic        is_lui;
   logic        is_auipc;

   assign maj      = instr_in[6:0];
   assign f3       = instr_in[14:12];
   assign f7       = instr_in[31:25];
   assign imm_i    = {{20{instr_in[31]}}, instr_in[31:20]};
   assign imm_u    = {instr_in[31:12], 12'b0};
   assign is_op    = (maj == RV_OP);
   assign is_imm   = (maj == RV_OP_IMM);
   assign is_lui   = (maj == RV_LUI);
   assign is_auipc = (maj == RV_AUIPC);

   logic        bad;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [3:0]  opc;
   logic        ill;

   always_comb begin
      bad = 1'b0;
      op1 = rs1_data_in;
      op2 = rs2_data_in;
      opc = ALU_OP_ADD;
      ill = 1'b0;
      unique case (1'b1)
         is_op: begin
            if (f7 == F7_BASE)
               opc = {1'b0, f3};
            else if (f7 == F7_ALT && f3 == 3'b000)
               opc = ALU_OP_SUB;
            else if (f7 == F7_ALT && f3 == 3'b101)
               opc = ALU_OP_SRA;
            else
               bad = 1'b1;
         end
         is_imm: begin
            op2 = imm_i;
            if (f3 == 3'b001 && f7 != F7_BASE)
               bad = 1'b1;
            else if (f3 == 3'b101 && f7 == F7_ALT)
               opc = ALU_OP_SRA;
            else if (f3 == 3'b101 && f7 != F7_BASE)
               bad = 1'b1;
            else
               opc = {1'b0, f3};
         end
         is_lui: begin
            op1 = '0;
            op2 = imm_u;
         end
         is_auipc: begin
            op1 = pc_in;
            op2 = imm_u;
         end
         default: bad = 1'b1;
      endcase
      // ALU shifts by the whole op2, so only the 5-bit amount may pass
      if (is_shift(opc))
         op2 = {27'b0, op2[4:0]};
      if (bad) begin
         op1 = rs1_data_in;
         op2 = rs2_data_in;
`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
         opc = ALU_OP_ILLEGAL;
         ill = 1'b1;
`else
         opc = ALU_OP_ADD;
`endif
      end
      dec_out = '{op1: op1, op2: op2, opcode: opc,
                  rd: instr_in[11:7], illegal: ill};
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode plus 2-entry skid buffer with valid/ready.
// Ports: clk_in, rst_in, flush_in; upstream instr/rs1/rs2/pc, valid_in,
// ready_out; downstream op1/op2/opcode/rd/illegal, valid_out, ready_in.
// Macro ALU_ISSUE_ILLEGAL_CHK_EN enables illegal-encoding flagging.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            flush_in,
   input  logic [XLEN-1:0] instr_in,
   input  logic [XLEN-1:0] rs1_data_in,
   input  logic [XLEN-1:0] rs2_data_in,
   input  logic [XLEN-1:0] pc_in,
   input  logic            valid_in,
   output logic            ready_out,
   output logic [XLEN-1:0] op1_out,
   output logic [XLEN-1:0] op2_out,
   output logic [3:0]      opcode_out,
   output logic [4:0]      rd_out,
   output logic            illegal_out,
   output logic            valid_out,
   input  logic            ready_in
);

   buf_state_e state_q, state_d;
   issue_t     main_q, main_d;
   issue_t     skid_q, skid_d;
   issue_t     dec;
   logic       accept;
   logic       deliver;

   alu_issue_decode #(.XLEN(XLEN)) u_dec (
      .instr_in    (instr_in),
      .rs1_data_in (rs1_data_in),
      .rs2_data_in (rs2_data_in),
      .pc_in       (pc_in),
      .dec_out     (dec)
   );

   assign accept  = valid_in & ready_out;
   assign deliver = valid_out & ready_in;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= BUF_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush_in) begin
         state_d = BUF_EMPTY;
         main_d  = '0;
         skid_d  = '0;
      end else begin
         unique case (state_q)
            BUF_EMPTY: begin
               if (accept) begin
                  main_d  = dec;
                  state_d = BUF_ONE;
               end
            end
            BUF_ONE: begin
               if (accept && deliver) begin
                  main_d = dec;
               end else if (accept) begin
                  // main is stalled: park the new beat behind it
                  skid_d  = dec;
                  state_d = BUF_FULL;
               end else if (deliver) begin
                  state_d = BUF_EMPTY;
               end
            end
            BUF_FULL: begin
               if (deliver) begin
                  main_d  = skid_q;
                  state_d = BUF_ONE;
               end
            end
            default: state_d = BUF_EMPTY;
         endcase
      end
   end

   always_comb begin
      ready_out   = (state_q != BUF_FULL);
      valid_out   = (state_q != BUF_EMPTY);
      op1_out     = main_q.op1;
      op2_out     = main_q.op2;
      opcode_out  = main_q.opcode;
      rd_out      = main_q.rd;
      illegal_out = main_q.illegal;
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage.
// Queue-based reference model plus directed literal checks.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        vin = 1'b0;
   logic        rin = 1'b1;
   logic [31:0] instr = '0;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   logic [31:0] pc = '0;
   logic        ready_out;
   logic [31:0] op1_out;
   logic [31:0] op2_out;
   logic [3:0]  opcode_out;
   logic [4:0]  rd_out;
   logic        illegal_out;
   logic        valid_out;

   always #5 clk = ~clk;

   alu_issue_stage #(.XLEN(32)) dut (
      .clk_in      (clk),
      .rst_in      (rst),
      .flush_in    (flush),
      .instr_in    (instr),
      .rs1_data_in (rs1),
      .rs2_data_in (rs2),
      .pc_in       (pc),
      .valid_in    (vin),
      .ready_out   (ready_out),
      .op1_out     (op1_out),
      .op2_out     (op2_out),
      .opcode_out  (opcode_out),
      .rd_out      (rd_out),
      .illegal_out (illegal_out),
      .valid_out   (valid_out),
      .ready_in    (rin)
   );

   typedef struct {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [3:0]  opc;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] ins,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  input logic [31:0] p);
      exp_t e;
      logic bad;
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = ins[14:12];
      f7 = ins[31:25];
      bad = 1'b0;
      e.rd = ins[11:7];
      e.op1 = a;
      e.op2 = b;
      e.opc = 4'h0;
      e.ill = 1'b0;
      case (ins[6:0])
         7'h33: begin
            if (f7 == 7'h00) e.opc = {1'b0, f3};
            else if (f7 == 7'h20 && f3 == 3'd0) e.opc = 4'h8;
            else if (f7 == 7'h20 && f3 == 3'd5) e.opc = 4'hD;
            else bad = 1'b1;
         end
         7'h13: begin
            e.op2 = {{20{ins[31]}}, ins[31:20]};
            if (f3 == 3'd1) begin
               if (f7 == 7'h00) e.opc = 4'h1;
               else bad = 1'b1;
            end else if (f3 == 3'd5) begin
               if (f7 == 7'h00) e.opc = 4'h5;
               else if (f7 == 7'h20) e.opc = 4'hD;
               else bad = 1'b1;
            end else e.opc = {1'b0, f3};
         end
         7'h37: begin
            e.op1 = 32'h0;
            e.op2 = {ins[31:12], 12'h000};
         end
         7'h17: begin
            e.op1 = p;
            e.op2 = {ins[31:12], 12'h000};
         end
         default: bad = 1'b1;
      endcase
      if (e.opc == 4'h1 || e.opc == 4'h5 || e.opc == 4'hD)
         e.op2 = e.op2 % 32;
      if (bad) begin
         e.op1 = a;
         e.op2 = b;
`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
         e.opc = 4'hF;
         e.ill = 1'b1;
`else
         e.opc = 4'h0;
`endif
      end
      return e;
   endfunction

   // reference model: FIFO of at most two beats
   always @(posedge clk) begin
      automatic int sz = q.size();
      if (rst || flush) begin
         q.delete();
      end else begin
         if (sz != 0 && rin) q.delete(0);
         if (vin && sz < 2) q.push_back(model(instr, rs1, rs2, pc));
      end
   end

   always @(negedge clk) begin
      chk("valid_out", 32'(valid_out), 32'(q.size() != 0));
      chk("ready_out", 32'(ready_out), 32'(q.size() < 2));
      if (q.size() != 0) begin
         chk("m_op1", op1_out, q[0].op1);
         chk("m_op2", op2_out, q[0].op2);
         chk("m_opc", 32'(opcode_out), 32'(q[0].opc));
         chk("m_rd", 32'(rd_out), 32'(q[0].rd));
         chk("m_ill", 32'(illegal_out), 32'(q[0].ill));
      end
   end

   task automatic beat(input logic [31:0] i, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] p);
      @(negedge clk);
      instr = i;
      rs1 = a;
      rs2 = b;
      pc = p;
      vin = 1'b1;
   endtask

   task automatic idle();
      @(negedge clk);
      vin = 1'b0;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, 32'(valid_out), 32'h0);
      chk({tag, "_ready"}, 32'(ready_out), 32'h1);
      chk({tag, "_op1"}, op1_out, 32'h0);
      chk({tag, "_op2"}, op2_out, 32'h0);
      chk({tag, "_opc"}, 32'(opcode_out), 32'h0);
      chk({tag, "_rd"}, 32'(rd_out), 32'h0);
      chk({tag, "_ill"}, 32'(illegal_out), 32'h0);
   endtask

   localparam logic [31:0] ADDI  = 32'h00500093;
   localparam logic [31:0] SUB   = 32'h402081B3;
   localparam logic [31:0] SRAI  = 32'h40435293;
   localparam logic [31:0] SLL   = 32'h009413B3;
   localparam logic [31:0] SRL   = 32'h0020D233;
   localparam logic [31:0] LUI   = 32'h12345537;
   localparam logic [31:0] AUIPC = 32'hFFFFF597;
   localparam logic [31:0] ADDIN = 32'hFFF08613;
   localparam logic [31:0] MUL   = 32'h02208033;

   initial begin
      after_edge();
      chk_zero("rst");
      @(negedge clk);
      rst = 1'b0;

      beat(ADDI, 32'h0, 32'h0, 32'h0);
      after_edge();
      chk("addi_valid", 32'(valid_out), 32'h1);
      chk("addi_opc", 32'(opcode_out), 32'h0);
      chk("addi_op1", op1_out, 32'h0);
      chk("addi_op2", op2_out, 32'h5);
      chk("addi_rd", 32'(rd_out), 32'h1);

      beat(SUB, 32'd10, 32'd3, 32'h0);
      after_edge();
      chk("sub_opc", 32'(opcode_out), 32'h8);
      chk("sub_op1", op1_out, 32'd10);
      chk("sub_op2", op2_out, 32'd3);
      chk("sub_rd", 32'(rd_out), 32'd3);

      beat(SRAI, 32'h80000000, 32'h0, 32'h0);
      after_edge();
      chk("srai_opc", 32'(opcode_out), 32'hD);
      chk("srai_op2", op2_out, 32'h4);

      beat(SLL, 32'h1, 32'hFFFFFF21, 32'h0);
      after_edge();
      chk("sll_opc", 32'(opcode_out), 32'h1);
      chk("sll_op2", op2_out, 32'h1);

      beat(SRL, 32'h1, 32'h25, 32'h0);
      after_edge();
      chk("srl_opc", 32'(opcode_out), 32'h5);
      chk("srl_op2", op2_out, 32'h5);

      beat(LUI, 32'hDEAD, 32'hBEEF, 32'h0);
      after_edge();
      chk("lui_op1", op1_out, 32'h0);
      chk("lui_op2", op2_out, 32'h12345000);

      beat(AUIPC, 32'h0, 32'h0, 32'h1000);
      after_edge();
      chk("auipc_op1", op1_out, 32'h1000);
      chk("auipc_op2", op2_out, 32'hFFFFF000);

      beat(ADDIN, 32'h5, 32'h0, 32'h0);
      after_edge();
      chk("addin_op2", op2_out, 32'hFFFFFFFF);

      beat(MUL, 32'd7, 32'd9, 32'h0);
      after_edge();
`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
      chk("mul_ill", 32'(illegal_out), 32'h1);
      chk("mul_opc", 32'(opcode_out), 32'hF);
`else
      chk("mul_ill", 32'(illegal_out), 32'h0);
      chk("mul_opc", 32'(opcode_out), 32'h0);
      chk("mul_op1", op1_out, 32'd7);
      chk("mul_op2", op2_out, 32'd9);
`endif

      idle();
      after_edge();
      chk("drain_valid", 32'(valid_out), 32'h0);

      beat(ADDI, 32'h11, 32'h0, 32'h0);
      rin = 1'b0;
      after_edge();
      chk("bp_one_ready", 32'(ready_out), 32'h1);
      beat(SUB, 32'h22, 32'h1, 32'h0);
      after_edge();
      chk("bp_full_ready", 32'(ready_out), 32'h0);
      chk("bp_full_op1", op1_out, 32'h11);
      beat(ADDI, 32'h33, 32'h0, 32'h0);
      after_edge();
      chk("bp_hold_op1", op1_out, 32'h11);
      chk("bp_hold_ready", 32'(ready_out), 32'h0);
      @(negedge clk);
      rin = 1'b1;
      after_edge();
      chk("bp_second_op1", op1_out, 32'h22);
      after_edge();
      chk("bp_third_op1", op1_out, 32'h33);
      idle();
      after_edge();
      chk("bp_empty", 32'(valid_out), 32'h0);

      beat(ADDI, 32'h66, 32'h0, 32'h0);
      rin = 1'b0;
      after_edge();
      beat(SUB, 32'h77, 32'h1, 32'h0);
      after_edge();
      chk("rst_full_ready", 32'(ready_out), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      after_edge();
      chk_zero("rstfull");
      @(negedge clk);
      rst = 1'b0;
      rin = 1'b1;
      instr = ADDI;
      rs1 = 32'h44;
      after_edge();
      chk("post_rst_valid", 32'(valid_out), 32'h1);
      chk("post_rst_op1", op1_out, 32'h44);

      beat(SUB, 32'h55, 32'h2, 32'h0);
      rin = 1'b0;
      after_edge();
      beat(ADDI, 32'h88, 32'h0, 32'h0);
      flush = 1'b1;
      after_edge();
      chk_zero("flush");
      @(negedge clk);
      flush = 1'b0;
      vin = 1'b0;
      rin = 1'b1;
      after_edge();
      chk("post_flush_valid", 32'(valid_out), 32'h0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
